// File: rtl/rob_pkg.sv
// Shared types and default sizing for the reorder buffer and the CDB that feeds it.
package rob_pkg;

  localparam int ROB_DEPTH_DEF = 4;
  localparam int CDB_SIZE_DEF  = 3;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
  } rob_entry_t;

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocation, out-of-order CDB completion, in-order commit,
// plus two operand-readiness lookup ports with same-cycle CDB bypass.
module rob
  import rob_pkg::*;
#(
  parameter int CDB_SIZE  = CDB_SIZE_DEF,
  parameter int ROB_DEPTH = ROB_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 disp_valid,
  input  logic [4:0]           disp_rd_s,
  output logic                 disp_ready,
  output logic [ROB_DEPTH-1:0] disp_rob,
  input  logic                 cdb_valid [CDB_SIZE],
  input  logic [31:0]          cdb_rd_v  [CDB_SIZE],
  input  logic [ROB_DEPTH-1:0] cdb_rob   [CDB_SIZE],
  input  logic [ROB_DEPTH-1:0] lk_rob    [2],
  output logic                 lk_ready  [2],
  output logic [31:0]          lk_v      [2],
  output logic                 commit_valid,
  output logic [4:0]           commit_rd_s,
  output logic [31:0]          commit_rd_v,
  output logic [ROB_DEPTH-1:0] commit_rob,
  input  logic                 flush
);

  localparam int ENTRIES = 2 ** ROB_DEPTH;

  rob_entry_t           ent_q [ENTRIES];
  rob_entry_t           ent_d [ENTRIES];
  logic [ROB_DEPTH:0]   head_q, head_d, tail_q, tail_d;
  logic [ROB_DEPTH-1:0] head_idx, tail_idx;
  logic                 empty, full, disp_fire;
  rob_entry_t           head_ent;

  assign head_idx  = head_q[ROB_DEPTH-1:0];
  assign tail_idx  = tail_q[ROB_DEPTH-1:0];
  assign empty     = (head_q == tail_q);
  assign full      = (head_idx == tail_idx) && (head_q[ROB_DEPTH] != tail_q[ROB_DEPTH]);
  assign disp_ready = !full;
  assign disp_rob   = tail_idx;
  assign disp_fire  = disp_valid && !full;

  assign head_ent     = ent_q[head_idx];
  assign commit_valid = head_ent.valid && head_ent.done;
  assign commit_rd_s  = empty ? 5'd0  : head_ent.rd_s;
  assign commit_rd_v  = empty ? 32'd0 : head_ent.rd_v;
  assign commit_rob   = empty ? '0    : head_idx;

  // Capture tests the registered entry, so lanes are independent and a later lane overwrites.
  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    for (int l = 0; l < CDB_SIZE; l++) begin
      if (cdb_valid[l] && ent_q[cdb_rob[l]].valid && !ent_q[cdb_rob[l]].done) begin
        ent_d[cdb_rob[l]].done = 1'b1;
        ent_d[cdb_rob[l]].rd_v = cdb_rd_v[l];
      end
    end
    if (commit_valid) begin
      ent_d[head_idx].valid = 1'b0;
      ent_d[head_idx].done  = 1'b0;
      head_d = head_q + 1'b1;
    end
    if (disp_fire) begin
      ent_d[tail_idx] = '{valid: 1'b1, done: 1'b0, rd_s: disp_rd_s, rd_v: 32'd0};
      tail_d = tail_q + 1'b1;
    end
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_d[i].valid = 1'b0;
        ent_d[i].done  = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      ent_q  <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Lookup: stored done value first, then any matching live CDB lane overrides it.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      lk_ready[k] = 1'b0;
      lk_v[k]     = 32'd0;
      if (ent_q[lk_rob[k]].valid && ent_q[lk_rob[k]].done) begin
        lk_ready[k] = 1'b1;
        lk_v[k]     = ent_q[lk_rob[k]].rd_v;
      end
      for (int l = 0; l < CDB_SIZE; l++) begin
        if (cdb_valid[l] && (cdb_rob[l] == lk_rob[k])) begin
          lk_ready[k] = 1'b1;
          lk_v[k]     = cdb_rd_v[l];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int a = 0; a < CDB_SIZE; a++) begin
        for (int b = a + 1; b < CDB_SIZE; b++) begin
          assert (!(cdb_valid[a] && cdb_valid[b] && (cdb_rob[a] == cdb_rob[b])))
            else $error("rob: two CDB lanes carry the same tag");
        end
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Randomized plus directed bench for rob with a queue-based program-order reference model.
module tb_rob;
  localparam int CS = 3;
  localparam int RD = 4;
  localparam int NE = 16;

  logic          clk, rst_n;
  logic          disp_valid;
  logic [4:0]    disp_rd_s;
  logic          disp_ready;
  logic [RD-1:0] disp_rob;
  logic          cdb_valid [CS];
  logic [31:0]   cdb_rd_v  [CS];
  logic [RD-1:0] cdb_rob   [CS];
  logic [RD-1:0] lk_rob    [2];
  logic          lk_ready  [2];
  logic [31:0]   lk_v      [2];
  logic          commit_valid;
  logic [4:0]    commit_rd_s;
  logic [31:0]   commit_rd_v;
  logic [RD-1:0] commit_rob;
  logic          flush;

  rob #(.CDB_SIZE(CS), .ROB_DEPTH(RD)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_rd_s(disp_rd_s),
    .disp_ready(disp_ready), .disp_rob(disp_rob),
    .cdb_valid(cdb_valid), .cdb_rd_v(cdb_rd_v), .cdb_rob(cdb_rob),
    .lk_rob(lk_rob), .lk_ready(lk_ready), .lk_v(lk_v),
    .commit_valid(commit_valid), .commit_rd_s(commit_rd_s),
    .commit_rd_v(commit_rd_v), .commit_rob(commit_rob),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [RD-1:0] tag;
    logic [4:0]    rd_s;
    bit            done;
    logic [31:0]   v;
    bit            pushed;
  } ment_t;
  typedef struct {
    logic [RD-1:0] tag;
    logic [4:0]    rd_s;
    logic [31:0]   v;
  } exp_t;

  ment_t mq[$];     // in-flight instructions, oldest first
  exp_t  exp_q[$];  // commits the DUT owes
  int    m_tail;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    disp_valid = 1'b0;
    disp_rd_s  = 5'd0;
    flush      = 1'b0;
    for (int l = 0; l < CS; l++) begin
      cdb_valid[l] = 1'b0;
      cdb_rd_v[l]  = 32'd0;
      cdb_rob[l]   = '0;
    end
    lk_rob[0] = '0;
    lk_rob[1] = '0;
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_tail = 0;
  endtask

  function automatic void model_lk(input logic [RD-1:0] t, output bit r, output logic [31:0] v);
    r = 1'b0;
    v = 32'd0;
    foreach (mq[i]) if (mq[i].tag == t && mq[i].done) begin r = 1'b1; v = mq[i].v; end
    for (int l = 0; l < CS; l++) if (cdb_valid[l] && cdb_rob[l] == t) begin r = 1'b1; v = cdb_rd_v[l]; end
  endfunction

  // Apply one clock edge to the model using the inputs that were held during the cycle.
  task automatic model_edge();
    bit    acc;
    ment_t n;
    exp_t  e;
    if (flush) begin
      model_reset();
      return;
    end
    acc = disp_valid && (mq.size() < NE);
    for (int l = 0; l < CS; l++)
      if (cdb_valid[l])
        foreach (mq[i]) if (mq[i].tag == cdb_rob[l] && !mq[i].done) begin
          mq[i].done = 1'b1;
          mq[i].v    = cdb_rd_v[l];
        end
    if (mq.size() > 0 && mq[0].pushed) void'(mq.pop_front());
    if (acc) begin
      n.tag = RD'(m_tail); n.rd_s = disp_rd_s; n.done = 1'b0; n.v = 32'd0; n.pushed = 1'b0;
      mq.push_back(n);
      m_tail = (m_tail + 1) % (2 * NE);
    end
    if (mq.size() > 0 && mq[0].done && !mq[0].pushed) begin
      e.tag = mq[0].tag; e.rd_s = mq[0].rd_s; e.v = mq[0].v;
      exp_q.push_back(e);
      mq[0].pushed = 1'b1;
    end
  endtask

  task automatic check_comb();
    bit          r;
    logic [31:0] v;
    chk("disp_ready", 32'(disp_ready), 32'(mq.size() < NE));
    chk("disp_rob", 32'(disp_rob), 32'(m_tail % NE));
    for (int k = 0; k < 2; k++) begin
      model_lk(lk_rob[k], r, v);
      chk("lk_ready", 32'(lk_ready[k]), 32'(r));
      chk("lk_v", lk_v[k], v);
    end
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic tick();
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && !flush) begin
      chk("commit_valid", 32'(commit_valid), 32'(exp_q.size() > 0));
      if (commit_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("commit_rob", 32'(commit_rob), 32'(e.tag));
        chk("commit_rd_s", 32'(commit_rd_s), 32'(e.rd_s));
        chk("commit_rd_v", commit_rd_v, e.v);
      end
    end
  end

  task automatic rand_inputs();
    logic [RD-1:0] t;
    bit            dup;
    set_idle();
    disp_valid = ($urandom_range(0, 99) < 60);
    disp_rd_s  = 5'($urandom);
    for (int l = 0; l < CS; l++) begin
      if ($urandom_range(0, 1) == 1) begin
        if (mq.size() > 0 && $urandom_range(0, 3) != 0) t = mq[$urandom_range(0, mq.size() - 1)].tag;
        else t = RD'($urandom);
        dup = 1'b0;
        for (int j = 0; j < l; j++) if (cdb_valid[j] && cdb_rob[j] == t) dup = 1'b1;
        if (!dup) begin
          cdb_valid[l] = 1'b1;
          cdb_rob[l]   = t;
          cdb_rd_v[l]  = $urandom;
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (mq.size() > 0 && $urandom_range(0, 1) == 1) lk_rob[k] = mq[$urandom_range(0, mq.size() - 1)].tag;
      else lk_rob[k] = RD'($urandom);
    end
    flush = ($urandom_range(0, 99) == 0);
  endtask

  task automatic dispatch(input int n);
    for (int i = 0; i < n; i++) begin
      set_idle();
      disp_valid = 1'b1;
      disp_rd_s  = 5'(i + 1);
      tick();
    end
    set_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_disp_ready", 32'(disp_ready), 32'd1);
    chk("rst_disp_rob", 32'(disp_rob), 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_commit_rd_s", 32'(commit_rd_s), 32'd0);
    chk("rst_commit_rd_v", commit_rd_v, 32'd0);
    chk("rst_commit_rob", 32'(commit_rob), 32'd0);
    chk("rst_lk_ready", 32'(lk_ready[0]), 32'd0);
    chk("rst_lk_v", lk_v[1], 32'd0);
    rst_n = 1'b1;

    // Fill to 16, then a 17th request must be refused.
    for (int i = 0; i < NE; i++) begin
      set_idle();
      disp_valid = 1'b1;
      disp_rd_s  = 5'(i);
      #1 chk("fill_disp_rob", 32'(disp_rob), 32'(i));
      tick();
    end
    set_idle();
    disp_valid = 1'b1;
    #1 chk("full_disp_ready", 32'(disp_ready), 32'd0);
    tick();
    set_idle();
    flush = 1'b1;
    tick();

    // Out-of-order completion, in-order commit.
    dispatch(3);
    cdb_valid[0] = 1'b1; cdb_rob[0] = 4'd2; cdb_rd_v[0] = 32'hC; tick(); set_idle();
    cdb_valid[2] = 1'b1; cdb_rob[2] = 4'd1; cdb_rd_v[2] = 32'hB; tick(); set_idle();
    cdb_valid[1] = 1'b1; cdb_rob[1] = 4'd0; cdb_rd_v[1] = 32'hA; tick(); set_idle();
    chk("ooo_first_commit_v", commit_rd_v, 32'hA);
    repeat (4) tick();

    // Same-cycle bypass on lookup port 0.
    dispatch(1);
    cdb_valid[1] = 1'b1; cdb_rob[1] = 4'd3; cdb_rd_v[1] = 32'hDEAD; lk_rob[0] = 4'd3;
    #1;
    chk("bypass_ready", 32'(lk_ready[0]), 32'd1);
    chk("bypass_v", lk_v[0], 32'hDEAD);
    tick();
    set_idle();
    repeat (3) tick();

    // Full with the head completing: dispatch refused while it commits, accepted next cycle.
    dispatch(NE);
    disp_valid = 1'b1; cdb_valid[0] = 1'b1; cdb_rob[0] = 4'd4; cdb_rd_v[0] = 32'h44;
    tick();
    set_idle();
    disp_valid = 1'b1;
    #1;
    chk("fullc_commit_valid", 32'(commit_valid), 32'd1);
    chk("fullc_refused", 32'(disp_ready), 32'd0);
    tick();
    #1;
    chk("fullc_ready_again", 32'(disp_ready), 32'd1);
    chk("fullc_wrap_rob", 32'(disp_rob), 32'd4);
    tick();
    set_idle();
    flush = 1'b1;
    tick();
    set_idle();

    // Flush with pending entries and a CDB hit in the same cycle.
    dispatch(5);
    flush = 1'b1; cdb_valid[0] = 1'b1; cdb_rob[0] = 4'd0; cdb_rd_v[0] = 32'h1234;
    tick();
    set_idle();
    #1;
    chk("flush_disp_rob", 32'(disp_rob), 32'd0);
    chk("flush_no_commit", 32'(commit_valid), 32'd0);
    repeat (4) tick();

    for (int c = 0; c < 1500; c++) begin
      rand_inputs();
      tick();
    end
    set_idle();
    flush = 1'b1;
    tick();
    set_idle();

    // Asynchronous reset between edges while the head is ready to commit.
    dispatch(2);
    cdb_valid[0] = 1'b1; cdb_rob[0] = 4'd0; cdb_rd_v[0] = 32'h77;
    tick();
    set_idle();
    #1 chk("arst_pre_commit", 32'(commit_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_commit_valid", 32'(commit_valid), 32'd0);
    chk("arst_disp_ready", 32'(disp_ready), 32'd1);
    chk("arst_disp_rob", 32'(disp_rob), 32'd0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) tick();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rob.md
# rob

Reorder buffer directly downstream of the CDB. It allocates one entry per dispatched instruction and captures results from every CDB lane. It commits completed entries to the architectural register file strictly in program order. It also answers operand-readiness lookups from rename/dispatch, with same-cycle CDB bypass.

## Interface
Parameters:
- CDB_SIZE, 3, number of CDB lanes; must match the CDB instance.
- ROB_DEPTH, 4, ROB tag width in bits; entry count is 2**ROB_DEPTH (16 at default).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- disp_valid  in  1  dispatch requests an entry this cycle.
- disp_rd_s  in  5  destination architectural register; 0 means no register write.
- disp_ready  out  1  entry available; dispatch completes on disp_valid && disp_ready.
- disp_rob  out  ROB_DEPTH  tag that will be allocated (current tail index).
- cdb_valid[CDB_SIZE]  in  1 each  lane carries a result.
- cdb_rd_v[CDB_SIZE]  in  32 each  result value.
- cdb_rob[CDB_SIZE]  in  ROB_DEPTH each  tag of the producing entry.
- lk_rob[2]  in  ROB_DEPTH each  operand lookup tags.
- lk_ready[2]  out  1 each  looked-up entry is done, or is being written by the CDB this cycle.
- lk_v[2]  out  32 each  looked-up value; 0 when not ready.
- commit_valid  out  1  head entry retires this cycle.
- commit_rd_s  out  5  destination of the retiring entry.
- commit_rd_v  out  32  value of the retiring entry.
- commit_rob  out  ROB_DEPTH  tag of the retiring entry.
- flush  in  1  synchronous squash of all entries.

## Operation
- Each entry holds {valid, done, rd_s, rd_v}.
- head_ptr and tail_ptr are ROB_DEPTH+1 bits wide; the MSB is the wrap bit.
  - empty: head_ptr == tail_ptr.
  - full: index bits are equal and wrap bits differ.
- Dispatch:
  - disp_ready = !full. There is no same-cycle credit from commit.
  - An accepted dispatch writes {1, 0, disp_rd_s, 0} at the tail index and increments tail_ptr, wrapping naturally modulo 2**(ROB_DEPTH+1).
- CDB capture:
  - Every lane with cdb_valid whose tag hits a valid, not-done entry sets done = 1 and rd_v = cdb_rd_v.
  - Hits on invalid or already-done entries are ignored.
  - Two lanes carrying the same tag in one cycle is illegal. The simulation assertion fires; the higher lane index wins.
- Commit:
  - commit_valid = head entry valid && done. This is combinational from state and does not bypass the CDB.
  - commit_rd_s, commit_rd_v and commit_rob present the head entry.
  - When commit_valid is high, the head entry's valid is cleared and head_ptr increments at the edge.
  - Entries with rd_s = 0 still commit; the register file ignores x0.
  - At most one commit per cycle.
- Lookup:
  - If any cdb_valid lane matches lk_rob, return that lane's value with ready = 1.
  - Otherwise return the entry's done/rd_v.
  - An invalid entry returns ready = 0, v = 0.
- Flush:
  - Clears every valid/done bit and sets both pointers to 0.
  - Dominates dispatch, CDB capture and commit in the same cycle.
  - commit_valid is still shown combinationally that cycle, but the register file must gate it with flush.

## Timing
- Reset (rst_n low, asynchronous):
  - All entries are cleared and both pointers are 0.
  - disp_ready = 1, disp_rob = 0, commit_valid = 0, commit_rd_s/rd_v/rob = 0, lk_ready = 0, lk_v = 0.
- Dispatch at edge N: the entry is visible to lookup (ready = 0) from cycle N+1.
- CDB result in cycle N: lookup sees it in cycle N via bypass and from state from N+1. If it is the head, commit_valid rises in N+1.
- Minimum dispatch-to-commit latency is 2 cycles: dispatch at N, CDB at N+1, commit at N+2.
- Full with commit in the same cycle: the dispatch is refused, and disp_ready rises the next cycle.
- Empty: commit_valid = 0, and the head outputs show entry 0 fields masked to 0.
- Reset asserted mid-operation drops all in-flight entries immediately, without waiting for a clock edge.

## Structure
- Shared package rob_pkg:
  - rob_entry_t struct {valid, done, rd_s[4:0], rd_v[31:0]}.
  - Default constants for ROB_DEPTH and CDB_SIZE, which the CDB instance reuses.
- No sub-module. Pointer, full/empty and lookup logic live inline; the CDB match loop is an always_comb over CDB_SIZE.

## Test plan
- Reset then 16 dispatches with no CDB -> disp_rob runs 0..15, disp_ready goes 0 after the 16th, and the 17th disp_valid is not accepted.
- Dispatch tags 0,1,2; CDB completes tag 2 (0xC), then 1 (0xB), then 0 (0xA) -> commits appear in order 0,1,2 with 0xA, 0xB, 0xC, one per cycle, starting the cycle after tag 0 completes.
- Tag 3 pending; lane 1 broadcasts tag 3 = 0xDEAD while lk_rob[0] = 3 -> lk_ready[0] = 1 and lk_v[0] = 0xDEAD in the same cycle.
- Full ROB, head done, disp_valid high -> commit retires head; dispatch refused that cycle and accepted the next with disp_rob equal to the old head index (wrap-bit check).
- Flush with 5 entries pending and a CDB hit in the same cycle -> next cycle empty, disp_rob = 0, no commit ever issued for the flushed tags.
- Assert rst_n low between edges with entries done -> commit_valid drops immediately and disp_ready = 1.
